// File: rtl/axis_prog_loader_if.sv
// Stream bundle between the program-image source and the loader, plus the
// loader's command output toward the head of the CPU daisy chain.
interface axis_prog_loader_if;
    logic [31:0] prog_TDATA;
    logic        prog_TVALID;
    logic        prog_TREADY;
    logic        prog_TLAST;
    logic [31:0] cmd_out_TDATA;
    logic        cmd_out_TVALID;

    modport master (
        output prog_TDATA, prog_TVALID, prog_TLAST,
        input  prog_TREADY, cmd_out_TDATA, cmd_out_TVALID
    );

    modport slave (
        input  prog_TDATA, prog_TVALID, prog_TLAST,
        output prog_TREADY, cmd_out_TDATA, cmd_out_TVALID
    );
endinterface

// File: rtl/axis_prog_loader.sv
// Converts a framed program image into the register-map write sequence that
// programs one CPU: PROG=1, instructions, jump offsets, immediates, PROG=0.
module axis_prog_loader #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int REG_ADDR_WIDTH  = 4,
    parameter int CPU_ID_WIDTH    = 12,
    parameter int REG_PROG        = 0,
    parameter int REG_INST        = 1,
    parameter int REG_JMP_OFF     = 2,
    parameter int REG_IMM         = 3
) (
    input  logic                clk,
    input  logic                rst,
    axis_prog_loader_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [REG_ADDR_WIDTH-1:0] RA_PROG = REG_ADDR_WIDTH'(REG_PROG);
    localparam logic [REG_ADDR_WIDTH-1:0] RA_INST = REG_ADDR_WIDTH'(REG_INST);
    localparam logic [REG_ADDR_WIDTH-1:0] RA_JMP  = REG_ADDR_WIDTH'(REG_JMP_OFF);
    localparam logic [REG_ADDR_WIDTH-1:0] RA_IMM  = REG_ADDR_WIDTH'(REG_IMM);
    localparam logic [31:0]               MAX_INST = 32'(1) << CODE_ADDR_WIDTH;

    typedef enum logic [3:0] {
        IDLE, HDR, PON_A, PON_D, BODY_A, BODY_D, POFF_A, POFF_D, DRAIN
    } state_t;

    typedef enum logic [1:0] {SEC_INST, SEC_JMP, SEC_IMM} sec_t;

    state_t                    state;
    sec_t                      sec;
    sec_t                      next_sec;
    sec_t                      first_sec;
    logic [CPU_ID_WIDTH-1:0]   id;
    logic [15:0]               cnt_inst;
    logic [4:0]                cnt_jmp;
    logic [4:0]                cnt_imm;
    logic [31:0]               data_q;
    logic                      last_q;
    logic                      drain_after;
    logic                      empty_img;
    logic [31:0]               cmd_data;
    logic                      cmd_valid;

    logic                      hs;
    logic [15:0]               h_inst;
    logic [4:0]                h_jmp;
    logic [4:0]                h_imm;
    logic                      h_ok;
    logic                      h_empty;
    logic [REG_ADDR_WIDTH-1:0] sec_reg;
    logic [31:0]               sec_data;
    logic                      last_body;

    function automatic logic [31:0] addr_word(input logic [CPU_ID_WIDTH-1:0] cpu,
                                              input logic [REG_ADDR_WIDTH-1:0] r);
        logic [31:0] w;
        w = '0;
        w[REG_ADDR_WIDTH +: CPU_ID_WIDTH] = cpu;
        w[REG_ADDR_WIDTH-1:0]             = r;
        return w;
    endfunction

    assign hs              = bus.prog_TVALID && bus.prog_TREADY;
    assign bus.prog_TREADY = (state == IDLE) || (state == HDR) ||
                             (state == BODY_A) || (state == DRAIN);
    assign bus.cmd_out_TDATA  = cmd_data;
    assign bus.cmd_out_TVALID = cmd_valid;
    assign busy = (state != IDLE);

    assign h_inst  = bus.prog_TDATA[15:0];
    assign h_jmp   = bus.prog_TDATA[20:16];
    assign h_imm   = bus.prog_TDATA[25:21];
    assign h_ok    = ({16'd0, h_inst} <= MAX_INST) && (h_jmp <= 5'd16) && (h_imm <= 5'd16);
    assign h_empty = (h_inst == 16'd0) && (h_jmp == 5'd0) && (h_imm == 5'd0);

    // Section bookkeeping: empty sections are skipped both at entry and on advance.
    always_comb begin
        first_sec = SEC_IMM;
        if (h_inst != 16'd0)
            first_sec = SEC_INST;
        else if (h_jmp != 5'd0)
            first_sec = SEC_JMP;

        next_sec  = sec;
        last_body = 1'b0;
        sec_reg   = RA_IMM;
        sec_data  = bus.prog_TDATA;
        case (sec)
            SEC_INST: begin
                sec_reg   = RA_INST;
                sec_data  = {24'd0, bus.prog_TDATA[7:0]};
                last_body = (cnt_inst == 16'd1) && (cnt_jmp == 5'd0) && (cnt_imm == 5'd0);
                if (cnt_inst == 16'd1)
                    next_sec = (cnt_jmp != 5'd0) ? SEC_JMP : SEC_IMM;
            end
            SEC_JMP: begin
                sec_reg   = RA_JMP;
                sec_data  = {24'd0, bus.prog_TDATA[7:0]};
                last_body = (cnt_jmp == 5'd1) && (cnt_imm == 5'd0);
                if (cnt_jmp == 5'd1)
                    next_sec = SEC_IMM;
            end
            default: begin
                last_body = (cnt_imm == 5'd1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sec         <= SEC_INST;
            id          <= '0;
            cnt_inst    <= '0;
            cnt_jmp     <= '0;
            cnt_imm     <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            drain_after <= 1'b0;
            empty_img   <= 1'b0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_data  <= '0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        id    <= bus.prog_TDATA[CPU_ID_WIDTH-1:0];
                        err   <= bus.prog_TLAST;
                        state <= bus.prog_TLAST ? IDLE : HDR;
                    end
                end
                HDR: begin
                    if (hs) begin
                        cnt_inst    <= h_inst;
                        cnt_jmp     <= h_jmp;
                        cnt_imm     <= h_imm;
                        sec         <= first_sec;
                        empty_img   <= h_empty;
                        drain_after <= h_empty && !bus.prog_TLAST;
                        if (!h_ok) begin
                            err   <= 1'b1;
                            state <= bus.prog_TLAST ? IDLE : DRAIN;
                        end else if (h_empty) begin
                            if (!bus.prog_TLAST)
                                err <= 1'b1;
                            state <= PON_A;
                        end else if (bus.prog_TLAST) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= PON_A;
                        end
                    end
                end
                PON_A: begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= addr_word(id, RA_PROG);
                    state     <= PON_D;
                end
                PON_D: begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= 32'd1;
                    state     <= empty_img ? POFF_A : BODY_A;
                end
                BODY_A: begin
                    if (hs) begin
                        cmd_valid <= 1'b1;
                        cmd_data  <= addr_word(id, sec_reg);
                        data_q    <= sec_data;
                        last_q    <= bus.prog_TLAST;
                        state     <= BODY_D;
                    end
                end
                // A TLAST mismatch still closes programming mode; only a missing
                // TLAST needs the rest of the frame drained.
                BODY_D: begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= data_q;
                    case (sec)
                        SEC_INST: cnt_inst <= cnt_inst - 16'd1;
                        SEC_JMP:  cnt_jmp  <= cnt_jmp - 5'd1;
                        default:  cnt_imm  <= cnt_imm - 5'd1;
                    endcase
                    if (last_body) begin
                        if (!last_q) begin
                            err         <= 1'b1;
                            drain_after <= 1'b1;
                        end
                        state <= POFF_A;
                    end else if (last_q) begin
                        err         <= 1'b1;
                        drain_after <= 1'b0;
                        state       <= POFF_A;
                    end else begin
                        sec   <= next_sec;
                        state <= BODY_A;
                    end
                end
                POFF_A: begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= addr_word(id, RA_PROG);
                    state     <= POFF_D;
                end
                POFF_D: begin
                    cmd_valid <= 1'b1;
                    cmd_data  <= 32'd0;
                    done      <= !err;
                    state     <= drain_after ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (hs && bus.prog_TLAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_prog_loader.sv
// Scoreboard bench for axis_prog_loader: stimulus pushes expected command
// words, an independent monitor pops and compares every emitted word.
module tb_axis_prog_loader;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic done;
    logic err;

    axis_prog_loader_if bus();

    axis_prog_loader dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    int          n_vec     = 0;
    int          n_miss    = 0;
    int          done_cnt  = 0;
    int          rate_viol = 0;
    bit          rate_en   = 1'b0;
    bit          prev_hs   = 1'b0;
    bit          hs_now;
    bit          gaps      = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(a);
        exp_q.push_back(d);
    endtask

    // Drives one image word and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        int g;
        if (gaps)
            while ($urandom_range(0, 1) == 1) @(negedge clk);
        @(negedge clk);
        bus.prog_TDATA  = d;
        bus.prog_TLAST  = l;
        bus.prog_TVALID = 1'b1;
        g = 0;
        while (!bus.prog_TREADY && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL tready_timeout: got no TREADY, expected TREADY within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.prog_TVALID = 1'b0;
        bus.prog_TLAST  = 1'b0;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 300) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (g >= 300) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL idle_timeout: got busy/pending words, expected idle within 300 cycles");
        end
    endtask

    task automatic basicImage(input logic [11:0] cpu, input bit with_gaps);
        logic [31:0] base;
        int          d0;
        base = {16'd0, cpu, 4'h0};
        d0   = done_cnt;
        gaps = with_gaps;
        expectWrite(base | 32'd0, 32'd1);
        expectWrite(base | 32'd1, 32'hA1);
        expectWrite(base | 32'd1, 32'hB2);
        expectWrite(base | 32'd2, 32'h07);
        expectWrite(base | 32'd3, 32'hDEADBEEF);
        expectWrite(base | 32'd0, 32'd0);
        applyStimulus({20'd0, cpu}, 1'b0);
        checkOutput("err_clear_on_h0", {31'd0, err}, 32'd0);
        applyStimulus(32'h0021_0002, 1'b0);
        rate_en = 1'b1;
        applyStimulus(32'hFFFF_FFA1, 1'b0);
        applyStimulus(32'h0000_01B2, 1'b0);
        applyStimulus(32'h0000_0007, 1'b0);
        applyStimulus(32'hDEADBEEF, 1'b1);
        waitIdle();
        rate_en = 1'b0;
        gaps    = 1'b0;
        checkOutput("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("basic_err", {31'd0, err}, 32'd0);
        checkOutput("basic_busy", {31'd0, busy}, 32'd0);
        checkOutput("body_rate", 32'(rate_viol), 32'd0);
    endtask

    // Scoreboard monitor: every valid command word must match the queue head.
    always @(negedge clk) begin
        if (done)
            done_cnt++;
        if (bus.cmd_out_TVALID) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL cmd_unexpected: got 0x%08h, expected no word", bus.cmd_out_TDATA);
            end else begin
                exp_w = exp_q.pop_front();
                checkOutput("cmd_word", bus.cmd_out_TDATA, exp_w);
            end
        end else if (bus.cmd_out_TDATA != 32'd0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL cmd_idle_data: got 0x%08h, expected 0x00000000", bus.cmd_out_TDATA);
        end
    end

    always @(posedge clk) begin
        hs_now = bus.prog_TVALID && bus.prog_TREADY;
        if (rate_en && hs_now && prev_hs)
            rate_viol++;
        prev_hs = hs_now;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        rst             = 1'b1;
        bus.prog_TDATA  = '0;
        bus.prog_TVALID = 1'b0;
        bus.prog_TLAST  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tready", {31'd0, bus.prog_TREADY}, 32'd1);
        checkOutput("rst_tvalid", {31'd0, bus.cmd_out_TVALID}, 32'd0);
        checkOutput("rst_tdata", bus.cmd_out_TDATA, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        $display("[TB] basic image, back-to-back words");
        basicImage(12'd5, 1'b0);

        $display("[TB] all-zero counts, TLAST on H1");
        d0 = done_cnt;
        expectWrite(32'h90, 32'd1);
        expectWrite(32'h90, 32'd0);
        applyStimulus(32'd9, 1'b0);
        applyStimulus(32'd0, 1'b1);
        waitIdle();
        checkOutput("empty_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("empty_err", {31'd0, err}, 32'd0);

        $display("[TB] n_jmp=17 rejected and drained");
        d0 = done_cnt;
        applyStimulus(32'd3, 1'b0);
        applyStimulus(32'h0011_0000, 1'b0);
        applyStimulus(32'h1, 1'b0);
        applyStimulus(32'h2, 1'b0);
        applyStimulus(32'h3, 1'b1);
        waitIdle();
        checkOutput("badhdr_err", {31'd0, err}, 32'd1);
        checkOutput("badhdr_done_pulses", 32'(done_cnt - d0), 32'd0);
        checkOutput("badhdr_tready", {31'd0, bus.prog_TREADY}, 32'd1);
        basicImage(12'd6, 1'b0);

        $display("[TB] early TLAST on first of three instructions");
        d0 = done_cnt;
        expectWrite(32'h20, 32'd1);
        expectWrite(32'h21, 32'h11);
        expectWrite(32'h20, 32'd0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        applyStimulus(32'h11, 1'b1);
        waitIdle();
        checkOutput("early_err", {31'd0, err}, 32'd1);
        checkOutput("early_busy", {31'd0, busy}, 32'd0);
        checkOutput("early_done_pulses", 32'(done_cnt - d0), 32'd0);

        $display("[TB] basic image with random TVALID gaps");
        basicImage(12'd5, 1'b1);

        $display("[TB] reset during BODY_D");
        exp_q.push_back(32'h40);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h41);
        applyStimulus(32'd4, 1'b0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'h33, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_tvalid", {31'd0, bus.cmd_out_TVALID}, 32'd0);
        checkOutput("midrst_tready", {31'd0, bus.prog_TREADY}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
